// File: rtl/jpc_ifetch.sv
// Instruction fetch stage: PC register, req/ack instruction-memory port and instr/valid/ready to decode.
// Optional build macro JPC_IFETCH_ALIGN_CHECK_EN makes a misaligned redirect target a fetch error.
module jpc_ifetch #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_O,
  output logic [31:0] mem_addr_O,
  input  logic        mem_ack_I,
  input  logic [31:0] mem_rdata_I,
  input  logic        mem_err_I,
  output logic [31:0] instr_O,
  output logic [31:0] pc_O,
  output logic        instr_valid_O,
  input  logic        instr_ready_I,
  input  logic        redirect_I,
  input  logic [31:0] redirect_pc_I,
  output logic        fetch_err_O
);

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    WAIT_ACK = 3'b001,
    HOLD     = 3'b011,
    ERROR    = 3'b100
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [31:0] pc;
  logic [7:0]  cnt;

  // NOTE: every register here is state, so all assignments are non-blocking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      cnt           <= 8'd0;
      mem_req_O     <= 1'b0;
      mem_addr_O    <= 32'd0;
      instr_O       <= 32'd0;
      pc_O          <= 32'd0;
      instr_valid_O <= 1'b0;
      fetch_err_O   <= 1'b0;
    end else if (redirect_I) begin
      // Redirect wins over ack, handshake and timeout; a coincident ack is dropped.
      mem_req_O     <= 1'b0;
      instr_valid_O <= 1'b0;
      cnt           <= 8'd0;
`ifdef JPC_IFETCH_ALIGN_CHECK_EN
      if (redirect_pc_I[1:0] != 2'b00) begin
        pc          <= redirect_pc_I;
        fetch_err_O <= 1'b1;
        state       <= ERROR;
      end else begin
        pc          <= redirect_pc_I;
        fetch_err_O <= 1'b0;
        state       <= IDLE;
      end
`else
      pc          <= redirect_pc_I & ~32'h3;
      fetch_err_O <= 1'b0;
      state       <= IDLE;
`endif
    end else begin
      case (state)
        IDLE: begin
          mem_req_O  <= 1'b1;
          mem_addr_O <= pc;
          cnt        <= 8'd0;
          state      <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (mem_ack_I && !mem_err_I) begin
            mem_req_O     <= 1'b0;
            instr_O       <= mem_rdata_I;
            pc_O          <= pc;
            instr_valid_O <= 1'b1;
            pc            <= pc + 32'd4;
            state         <= HOLD;
          end else if (mem_ack_I) begin
            mem_req_O   <= 1'b0;
            fetch_err_O <= 1'b1;
            state       <= ERROR;
          end else if (TIMEOUT_CYCLES != 0 && cnt == TIMEOUT_LAST) begin
            // Request has now been high for exactly TIMEOUT_CYCLES cycles.
            mem_req_O   <= 1'b0;
            fetch_err_O <= 1'b1;
            state       <= ERROR;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        HOLD: begin
          if (instr_valid_O && instr_ready_I) begin
            instr_valid_O <= 1'b0;
            state         <= IDLE;
          end
        end
        ERROR: begin
          mem_req_O     <= 1'b0;
          instr_valid_O <= 1'b0;
        end
        // NOTE: unreachable encodings recover to IDLE rather than lock up.
        default: begin
          mem_req_O     <= 1'b0;
          instr_valid_O <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jpc_ifetch.sv
// Directed bench for jpc_ifetch: fetch, backpressure, redirect, timeout, PC wrap, bus error, reset.
module tb_jpc_ifetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req_O;
  logic [31:0] mem_addr_O;
  logic        mem_ack_I = 1'b0;
  logic [31:0] mem_rdata_I = 32'd0;
  logic        mem_err_I = 1'b0;
  logic [31:0] instr_O;
  logic [31:0] pc_O;
  logic        instr_valid_O;
  logic        instr_ready_I = 1'b0;
  logic        redirect_I = 1'b0;
  logic [31:0] redirect_pc_I = 32'd0;
  logic        fetch_err_O;

  int n_checks = 0;
  int n_fail   = 0;

  jpc_ifetch #(.RESET_PC(32'h0000_0100), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .mem_req_O(mem_req_O), .mem_addr_O(mem_addr_O),
    .mem_ack_I(mem_ack_I), .mem_rdata_I(mem_rdata_I), .mem_err_I(mem_err_I),
    .instr_O(instr_O), .pc_O(pc_O), .instr_valid_O(instr_valid_O),
    .instr_ready_I(instr_ready_I),
    .redirect_I(redirect_I), .redirect_pc_I(redirect_pc_I),
    .fetch_err_O(fetch_err_O)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_checks++;
    if ({mem_req_O, instr_valid_O, fetch_err_O} !== 3'b000 || mem_addr_O !== 32'd0
        || instr_O !== 32'd0 || pc_O !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%b valid=%b err=%b addr=%h instr=%h pc=%h, want all 0",
               mem_req_O, instr_valid_O, fetch_err_O, mem_addr_O, instr_O, pc_O);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (mem_req_O !== 1'b1 || mem_addr_O !== 32'h100) begin
      n_fail++;
      $display("FAIL first_request: req=%b addr=%h, want 1 00000100", mem_req_O, mem_addr_O);
    end
  endtask

  task automatic test_fetch();
    mem_ack_I   = 1'b1;
    mem_rdata_I = 32'h0050_0093;
    tick();
    mem_ack_I   = 1'b0;
    mem_rdata_I = 32'd0;
    n_checks++;
    if (instr_valid_O !== 1'b1 || instr_O !== 32'h0050_0093 || pc_O !== 32'h100 || mem_req_O !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_present: valid=%b instr=%h pc=%h req=%b, want 1 00500093 00000100 0",
               instr_valid_O, instr_O, pc_O, mem_req_O);
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (instr_valid_O !== 1'b1 || instr_O !== 32'h0050_0093 || pc_O !== 32'h100 || mem_req_O !== 1'b0)
        bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL backpressure_stable: %0d unstable cycles, want 0", bad);
    end
    instr_ready_I = 1'b1;
    tick();
    instr_ready_I = 1'b0;
    n_checks++;
    if (instr_valid_O !== 1'b0) begin
      n_fail++;
      $display("FAIL handshake_drop: valid=%b, want 0", instr_valid_O);
    end
    tick();
    n_checks++;
    if (mem_req_O !== 1'b1 || mem_addr_O !== 32'h104) begin
      n_fail++;
      $display("FAIL next_fetch: req=%b addr=%h, want 1 00000104", mem_req_O, mem_addr_O);
    end
  endtask

  task automatic test_redirect_ack();
    mem_ack_I     = 1'b1;
    mem_rdata_I   = 32'hDEAD_BEEF;
    redirect_I    = 1'b1;
    redirect_pc_I = 32'h200;
    tick();
    mem_ack_I  = 1'b0;
    redirect_I = 1'b0;
    n_checks++;
    if (instr_valid_O !== 1'b0 || mem_req_O !== 1'b0) begin
      n_fail++;
      $display("FAIL redirect_drop_ack: valid=%b req=%b, want 0 0", instr_valid_O, mem_req_O);
    end
    tick();
    n_checks++;
    if (mem_req_O !== 1'b1 || mem_addr_O !== 32'h200 || instr_valid_O !== 1'b0) begin
      n_fail++;
      $display("FAIL redirect_target: req=%b addr=%h valid=%b, want 1 00000200 0",
               mem_req_O, mem_addr_O, instr_valid_O);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    while (mem_req_O === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    n_checks++;
    if (n != 16) begin
      n_fail++;
      $display("FAIL timeout_req_cycles: req high %0d cycles, want 16", n);
    end
    tick();
    tick();
    n_checks++;
    if (fetch_err_O !== 1'b1 || mem_req_O !== 1'b0 || instr_valid_O !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_error: err=%b req=%b valid=%b, want 1 0 0", fetch_err_O, mem_req_O, instr_valid_O);
    end
    redirect_I    = 1'b1;
    redirect_pc_I = 32'h0;
    tick();
    redirect_I = 1'b0;
    n_checks++;
    if (fetch_err_O !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear: err=%b, want 0", fetch_err_O);
    end
    tick();
    n_checks++;
    if (mem_req_O !== 1'b1 || mem_addr_O !== 32'h0) begin
      n_fail++;
      $display("FAIL timeout_restart: req=%b addr=%h, want 1 00000000", mem_req_O, mem_addr_O);
    end
  endtask

  task automatic test_wrap();
    redirect_I    = 1'b1;
    redirect_pc_I = 32'hFFFF_FFFC;
    tick();
    redirect_I = 1'b0;
    tick();
    n_checks++;
    if (mem_req_O !== 1'b1 || mem_addr_O !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_request: req=%b addr=%h, want 1 fffffffc", mem_req_O, mem_addr_O);
    end
    mem_ack_I   = 1'b1;
    mem_rdata_I = 32'h0000_0013;
    tick();
    mem_ack_I     = 1'b0;
    instr_ready_I = 1'b1;
    n_checks++;
    if (instr_valid_O !== 1'b1 || pc_O !== 32'hFFFF_FFFC || instr_O !== 32'h13) begin
      n_fail++;
      $display("FAIL wrap_present: valid=%b pc=%h instr=%h, want 1 fffffffc 00000013", instr_valid_O, pc_O, instr_O);
    end
    tick();
    instr_ready_I = 1'b0;
    tick();
    n_checks++;
    if (mem_req_O !== 1'b1 || mem_addr_O !== 32'h0 || fetch_err_O !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_next: req=%b addr=%h err=%b, want 1 00000000 0", mem_req_O, mem_addr_O, fetch_err_O);
    end
  endtask

  task automatic test_bus_err();
    mem_ack_I = 1'b1;
    mem_err_I = 1'b1;
    tick();
    mem_ack_I = 1'b0;
    mem_err_I = 1'b0;
    tick();
    n_checks++;
    if (fetch_err_O !== 1'b1 || instr_valid_O !== 1'b0 || mem_req_O !== 1'b0) begin
      n_fail++;
      $display("FAIL bus_error: err=%b valid=%b req=%b, want 1 0 0", fetch_err_O, instr_valid_O, mem_req_O);
    end
    redirect_I    = 1'b1;
    redirect_pc_I = 32'h202;
    tick();
    redirect_I = 1'b0;
    tick();
`ifdef JPC_IFETCH_ALIGN_CHECK_EN
    n_checks++;
    if (fetch_err_O !== 1'b1 || mem_req_O !== 1'b0) begin
      n_fail++;
      $display("FAIL misaligned_redirect: err=%b req=%b, want 1 0", fetch_err_O, mem_req_O);
    end
`else
    n_checks++;
    if (fetch_err_O !== 1'b0 || mem_req_O !== 1'b1 || mem_addr_O !== 32'h200) begin
      n_fail++;
      $display("FAIL misaligned_redirect: err=%b req=%b addr=%h, want 0 1 00000200", fetch_err_O, mem_req_O, mem_addr_O);
    end
`endif
  endtask

  task automatic test_reset_mid_fetch();
    redirect_I    = 1'b1;
    redirect_pc_I = 32'h300;
    tick();
    redirect_I = 1'b0;
    tick();
    mem_ack_I   = 1'b1;
    mem_rdata_I = 32'h1234_5678;
    rst         = 1'b1;
    #1;
    n_checks++;
    if ({mem_req_O, instr_valid_O, fetch_err_O} !== 3'b000 || mem_addr_O !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset: req=%b valid=%b err=%b addr=%h, want 0 0 0 00000000",
               mem_req_O, instr_valid_O, fetch_err_O, mem_addr_O);
    end
    tick();
    mem_ack_I = 1'b0;
    rst       = 1'b0;
    tick();
    n_checks++;
    if (mem_req_O !== 1'b1 || mem_addr_O !== 32'h100 || instr_valid_O !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_restart: req=%b addr=%h valid=%b, want 1 00000100 0", mem_req_O, mem_addr_O, instr_valid_O);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_backpressure();
    test_redirect_ack();
    test_timeout();
    test_wrap();
    test_bus_err();
    test_reset_mid_fetch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
